// File: rtl/serial_equality_checker_if.sv
// Handshake/result bundle between a serial bit source and serial_equality_checker.
interface serial_equality_checker_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             done;
  logic             equal;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] first_diff;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, equal, mismatch_cnt, first_diff
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, equal, mismatch_cnt, first_diff
  );
endinterface

// File: rtl/serial_equality_checker.sv
// Serial LSB-first frame comparator: per-bit XNOR accumulated into a registered verdict.
// Optional macro SEC_EARLY_ABORT_EN ends the frame at the first mismatching bit.
module serial_equality_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  serial_equality_checker_if.slave    bus
);

  if ((1 << CNT_W) <= WIDTH || WIDTH < 2) begin : g_bad_params
    $error("serial_equality_checker: need 2 <= WIDTH and 2**CNT_W > WIDTH");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [CNT_W-1:0] first_diff_q, first_diff_d;
  logic             seen_diff_q, seen_diff_d;
  logic             equal_q, equal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq;

  assign eq = ~(bus.a_bit ^ bus.b_bit);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d        = state_q;
    bit_idx_d      = bit_idx_q;
    mismatch_cnt_d = mismatch_cnt_q;
    first_diff_d   = first_diff_q;
    seen_diff_d    = seen_diff_q;
    equal_d        = equal_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d        = COMPARE;
          bit_idx_d      = '0;
          mismatch_cnt_d = '0;
          first_diff_d   = '0;
          seen_diff_d    = 1'b0;
          equal_d        = 1'b0;
        end
      end
      COMPARE: begin
        if (bus.bit_valid) begin
          bit_idx_d = bit_idx_q + 1'b1;
          if (!eq) begin
            mismatch_cnt_d = mismatch_cnt_q + 1'b1;
            if (!seen_diff_q) begin
              first_diff_d = bit_idx_q;
              seen_diff_d  = 1'b1;
            end
          end
          if (bit_idx_q == LAST_IDX) state_d = DONE;
`ifdef SEC_EARLY_ABORT_EN
          if (!eq) state_d = DONE;
`endif
          // Verdict uses the count including this bit so it lines up with done.
          if (state_d == DONE) equal_d = (mismatch_cnt_d == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == COMPARE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_idx_q      <= '0;
      mismatch_cnt_q <= '0;
      first_diff_q   <= '0;
      seen_diff_q    <= 1'b0;
      equal_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      bit_idx_q      <= bit_idx_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      first_diff_q   <= first_diff_d;
      seen_diff_q    <= seen_diff_d;
      equal_q        <= equal_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.equal        = equal_q;
  assign bus.mismatch_cnt = mismatch_cnt_q;
  assign bus.first_diff   = first_diff_q;

endmodule

// File: tb/tb_serial_equality_checker.sv
// Scoreboard bench for serial_equality_checker: random and directed frames vs. a frame-level model.
module tb_serial_equality_checker;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  serial_equality_checker_if #(.CNT_W(CNT_W)) sif ();

  serial_equality_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic eq;
    int   cnt;
    int   first;
    int   cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && sif.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("equal", int'(sif.equal), int'(e.eq));
        check("mismatch_cnt", int'(sif.mismatch_cnt), e.cnt);
        check("first_diff", int'(sif.first_diff), e.first);
        check("busy_in_done", int'(sif.busy), 0);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle_inputs();
    sif.start = 1'b0; sif.bit_valid = 1'b0; sif.a_bit = 1'b0; sif.b_bit = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, int'(sif.busy), 0);
    check({tag, "_done"}, int'(sif.done), 0);
    check({tag, "_equal"}, int'(sif.equal), 0);
    check({tag, "_cnt"}, int'(sif.mismatch_cnt), 0);
    check({tag, "_first"}, int'(sif.first_diff), 0);
  endtask

  // Sends one frame; the model works on whole words, not bit-by-bit state.
  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input int gap_at, input int gap_len, input bit extra);
    exp_t        e;
    logic [7:0]  d;
    int          n;
    d       = a ^ b;
    e.cnt   = $countones(d);
    e.first = 0;
    for (int i = WIDTH - 1; i >= 0; i--) if (d[i]) e.first = i;
    e.eq    = (d == 8'h00);
    n       = WIDTH;
`ifdef SEC_EARLY_ABORT_EN
    if (d != 8'h00) begin
      n     = e.first + 1;
      e.cnt = 1;
    end
`endif
    if (extra) begin
      @(posedge clk); #1;
      sif.bit_valid = 1'b1; sif.a_bit = 1'b1; sif.b_bit = 1'b0;
      @(posedge clk); #1;
      sif.bit_valid = 1'b0;
    end
    @(posedge clk); #1;
    sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    check("busy_after_start", int'(sif.busy), 1);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          sif.bit_valid = 1'b0;
          sif.a_bit = 1'b1; sif.b_bit = 1'b0;
          if (extra) sif.start = 1'b1;
          @(posedge clk); #1;
          sif.start = 1'b0;
        end
      end
      sif.bit_valid = 1'b1;
      sif.a_bit = a[i];
      sif.b_bit = b[i];
      if (extra && i == 2) sif.start = 1'b1;
      if (i == n - 1) begin
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      sif.start = 1'b0;
    end
    sif.bit_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    frame(8'hA5, 8'hA5, 0, 0, 1'b0);
    frame(8'hA5, 8'h5A, 0, 0, 1'b0);
    frame(8'h80, 8'h00, 4, 3, 1'b0);
    frame(8'h0F, 8'h0E, 0, 0, 1'b0);
    frame(8'h0F, 8'h0E, 5, 2, 1'b1);
    frame(8'h10, 8'h00, 0, 0, 1'b0);
    frame(8'hFF, 8'h00, 7, 1, 1'b0);

    // Mid-frame asynchronous reset after bit 4.
    @(posedge clk); #1;
    sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sif.bit_valid = 1'b1; sif.a_bit = 1'b1; sif.b_bit = 1'b0;
      @(posedge clk); #1;
    end
    sif.bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("post_reset");
    frame(8'h3C, 8'h3C, 0, 0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      frame(a, b, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
    #1 check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
